// File: rtl/leaf_feeder_pkg.sv
// leaf_feeder_pkg
//   Shared definitions for the leaf feeder of the merge sorter tree:
//   default widths, the tag width carried through the outstanding-fetch
//   queue, the all-ones end-of-channel sentinel and the run FSM encoding.
package leaf_feeder_pkg;

   localparam int W_LOG_DEF = 2;
   localparam int DATW_DEF  = 64;

   // Tags in the outstanding-fetch queue are channel indices.
   localparam int TAG_W = W_LOG_DEF;

   // End-of-channel marker returned once a channel has no records left.
   localparam logic [DATW_DEF-1:0] SENTINEL = {DATW_DEF{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/leaf_feeder_fifo.sv
// leaf_feeder_fifo
//   Register-based FIFO with power-of-two wrap-around pointers.
//   An enqueue while full is ignored; a dequeue while empty is ignored.
//   Ports:
//     CLK, RST  clock, synchronous active-low reset (empties the queue)
//     enq, din  push strobe and data
//     deq       pop strobe
//     dot       head entry (valid while emp==0)
//     emp, full queue empty / holds 2^AW entries
//     cnt       registered occupancy, 0..2^AW
module leaf_feeder_fifo #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          enq,
   input  logic          deq,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dot,
   output logic          emp,
   output logic          full,
   output logic [AW:0]   cnt
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_enq;
   logic          do_deq;

   assign emp    = (cnt == '0);
   assign full   = (cnt == (AW+1)'(DEPTH));
   assign do_enq = enq && !full;
   assign do_deq = deq && !emp;
   assign dot    = mem[rptr];

   always_ff @(posedge CLK) begin
      if (!RST) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_enq) wptr <= wptr + AW'(1);
         if (do_deq) rptr <= rptr + AW'(1);
         case ({do_enq, do_deq})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge CLK) begin
      if (do_enq) mem[wptr] <= din;
   end

endmodule

// File: rtl/leaf_feeder.sv
// leaf_feeder
//   Leaf-side responder of the merge sorter tree. Each channel request from
//   the bottom sorter stage is answered by exactly one record: the next
//   record fetched from the external source, or the all-ones sentinel once
//   the channel is exhausted.
//   Ports:
//     CLK, RST                   clock, synchronous active-low reset
//     START                      run start pulse (IDLE only)
//     LEN_WE, LEN_IDX, LEN       channel length load (IDLE only)
//     REQ, REQ_VALID, REQ_FULL   channel requests in, request queue full out
//     FETCH_IDX/VALID/READY      fetch command handshake to the source
//     SRC_DIN, SRC_VALID         records returned in fetch order
//     DOT, DOTEN, DOT_IDX        registered record strobe to the stage
//     BUSY, DONE, ERR            run status, completion pulse, sticky error
module leaf_feeder
   import leaf_feeder_pkg::*;
#(
   parameter int W_LOG   = TAG_W,
   parameter int DATW    = DATW_DEF,
   parameter int KEYW    = 32,
   parameter int REQ_LOG = 2,
   parameter int CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             LEN_WE,
   input  logic [W_LOG-1:0] LEN_IDX,
   input  logic [CNT_W-1:0] LEN,
   input  logic [W_LOG-1:0] REQ,
   input  logic             REQ_VALID,
   output logic             REQ_FULL,
   output logic [W_LOG-1:0] FETCH_IDX,
   output logic             FETCH_VALID,
   input  logic             FETCH_READY,
   input  logic [DATW-1:0]  SRC_DIN,
   input  logic             SRC_VALID,
   output logic [DATW-1:0]  DOT,
   output logic             DOTEN,
   output logic [W_LOG-1:0] DOT_IDX,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR
);

   localparam int NCH = 1 << W_LOG;

   // Key field and payload both saturated, so the sentinel sorts after
   // every real key in the tree.
   localparam logic [DATW-1:0] SENT = {{(DATW-KEYW){1'b1}}, {KEYW{1'b1}}};

   state_t             state;
   logic [CNT_W-1:0]   remaining [NCH];
   logic [NCH-1:0]     sent_sentinel;

   logic [W_LOG-1:0]   req_head;
   logic               req_emp;
   logic               req_full;
   logic [REQ_LOG:0]   req_cnt;
   logic [W_LOG-1:0]   tag_head;
   logic               tag_emp;
   logic               tag_full;
   logic [REQ_LOG:0]   tag_cnt;

   logic               in_run;
   logic               head_has_data;
   logic               fetch_go;
   logic               fetch_hs;
   logic               sent_go;
   logic               req_pop;
   logic               src_take;

   assign in_run        = (state == ST_RUN);
   assign head_has_data = (remaining[req_head] != '0);
   // A fetch may only be offered while a tag slot is free to remember it.
   assign fetch_go      = in_run && !req_emp && head_has_data && !tag_full;
   assign fetch_hs      = fetch_go && FETCH_READY;
   // The sentinel waits for every outstanding record, so it can neither
   // overtake data nor collide with a returning record on DOT.
   assign sent_go       = in_run && !req_emp && !head_has_data && (tag_cnt == '0);
   assign req_pop       = fetch_hs || sent_go;
   assign src_take      = SRC_VALID && !tag_emp;

   assign FETCH_VALID   = fetch_go;
   assign FETCH_IDX     = fetch_go ? req_head : '0;
   assign REQ_FULL      = (req_cnt == (REQ_LOG+1)'(1 << REQ_LOG));

   leaf_feeder_fifo #(.DW(W_LOG), .AW(REQ_LOG)) u_req_q (
      .CLK  (CLK),
      .RST  (RST),
      .enq  (REQ_VALID),
      .deq  (req_pop),
      .din  (REQ),
      .dot  (req_head),
      .emp  (req_emp),
      .full (req_full),
      .cnt  (req_cnt)
   );

   leaf_feeder_fifo #(.DW(W_LOG), .AW(REQ_LOG)) u_tag_q (
      .CLK  (CLK),
      .RST  (RST),
      .enq  (fetch_hs),
      .deq  (src_take),
      .din  (req_head),
      .dot  (tag_head),
      .emp  (tag_emp),
      .full (tag_full),
      .cnt  (tag_cnt)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state         <= ST_IDLE;
         BUSY          <= 1'b0;
         DONE          <= 1'b0;
         ERR           <= 1'b0;
         sent_sentinel <= '0;
         DOT           <= '0;
         DOTEN         <= 1'b0;
         DOT_IDX       <= '0;
         for (int i = 0; i < NCH; i++) remaining[i] <= '0;
      end else begin
         DONE  <= 1'b0;
         DOTEN <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (START) begin
                  state         <= ST_RUN;
                  BUSY          <= 1'b1;
                  sent_sentinel <= '0;
               end
            end
            ST_RUN: begin
               if (&sent_sentinel && (tag_cnt == '0)) begin
                  state <= ST_FIN;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
               end
            end
            ST_FIN:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         if ((state == ST_IDLE) && LEN_WE) remaining[LEN_IDX] <= LEN;
         if (fetch_hs) remaining[req_head] <= remaining[req_head] - CNT_W'(1);

         // Output stage: returned record or sentinel, registered onto DOT
         if (src_take) begin
            DOT     <= SRC_DIN;
            DOTEN   <= 1'b1;
            DOT_IDX <= tag_head;
         end else if (sent_go) begin
            DOT                     <= SENT;
            DOTEN                   <= 1'b1;
            DOT_IDX                 <= req_head;
            sent_sentinel[req_head] <= 1'b1;
         end

         if ((state == ST_IDLE) && START) ERR <= 1'b0;
         // Stray returns outside a run are leftovers of an aborted run
         // and are dropped without flagging.
         if ((REQ_VALID && req_full) || (SRC_VALID && tag_emp && (state != ST_IDLE)))
            ERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_leaf_feeder.sv
module tb_leaf_feeder;
   import leaf_feeder_pkg::*;

   localparam int W_LOG   = 2;
   localparam int DATW    = 64;
   localparam int KEYW    = 32;
   localparam int REQ_LOG = 2;
   localparam int CNT_W   = 32;
   localparam int NCH     = 4;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             START = 1'b0;
   logic             LEN_WE = 1'b0;
   logic [W_LOG-1:0] LEN_IDX = '0;
   logic [CNT_W-1:0] LEN = '0;
   logic [W_LOG-1:0] REQ = '0;
   logic             REQ_VALID = 1'b0;
   logic             REQ_FULL;
   logic [W_LOG-1:0] FETCH_IDX;
   logic             FETCH_VALID;
   logic             FETCH_READY = 1'b0;
   logic [DATW-1:0]  SRC_DIN = '0;
   logic             SRC_VALID = 1'b0;
   logic [DATW-1:0]  DOT;
   logic             DOTEN;
   logic [W_LOG-1:0] DOT_IDX;
   logic             BUSY;
   logic             DONE;
   logic             ERR;

   leaf_feeder #(.W_LOG(W_LOG), .DATW(DATW), .KEYW(KEYW), .REQ_LOG(REQ_LOG), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .LEN_WE(LEN_WE), .LEN_IDX(LEN_IDX), .LEN(LEN),
      .REQ(REQ), .REQ_VALID(REQ_VALID), .REQ_FULL(REQ_FULL),
      .FETCH_IDX(FETCH_IDX), .FETCH_VALID(FETCH_VALID), .FETCH_READY(FETCH_READY),
      .SRC_DIN(SRC_DIN), .SRC_VALID(SRC_VALID),
      .DOT(DOT), .DOTEN(DOTEN), .DOT_IDX(DOT_IDX), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   // ---------------- bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: every accepted request yields one output, in request order.
   logic [DATW-1:0]  exp_dat [$];
   logic [W_LOG-1:0] exp_idx [$];
   logic [W_LOG-1:0] fetch_q [$];
   int model_rem  [NCH];
   int model_used [NCH];

   // Record source model
   int              src_due [$];
   logic [DATW-1:0] src_dat [$];
   int src_cnt [NCH];
   int cyc = 0;
   int last_due = 0;
   int src_lat = 3;
   bit rand_lat = 0;
   bit rand_ready = 0;

   // Observation counters
   int fetch_cnt [NCH];
   int hs_total = 0;
   int first_src_hs = -1;
   bit seen_src = 0;
   bit log_en = 0;
   logic [DATW-1:0] log_dat [$];

   int tot, ch, g;

   function automatic logic [DATW-1:0] rec(int c, int k);
      return {4'hA, 12'(c), 16'(k), 32'(k * 40503 + c * 977 + 1)};
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic fail(string nm, string why);
      n_tests++;
      n_fail++;
      $display("FAIL %s: %s", nm, why);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_req(int c);
      if (model_rem[c] > 0) begin
         exp_dat.push_back(rec(c, model_used[c]));
         model_used[c]++;
         model_rem[c]--;
         fetch_q.push_back(2'(c));
      end else begin
         exp_dat.push_back(SENTINEL);
      end
      exp_idx.push_back(2'(c));
   endtask

   task automatic send_req(int c);
      int w = 0;
      while (REQ_FULL && w < 200) begin
         step();
         w++;
      end
      if (w >= 200) fail("req_space_timeout", "REQ_FULL stayed 1 for 200 cycles, required it to drop");
      REQ_VALID = 1'b1;
      REQ = 2'(c);
      model_req(c);
      step();
      REQ_VALID = 1'b0;
   endtask

   task automatic load_len(int c, int n);
      LEN_WE = 1'b1;
      LEN_IDX = 2'(c);
      LEN = 32'(n);
      model_rem[c] = n;
      step();
      LEN_WE = 1'b0;
   endtask

   task automatic start_run();
      START = 1'b1;
      step();
      START = 1'b0;
   endtask

   task automatic check_reset_outputs(string tag);
      chk({tag, "_dot"}, DOT, 64'h0);
      chk({tag, "_doten"}, DOTEN, 0);
      chk({tag, "_dot_idx"}, DOT_IDX, 0);
      chk({tag, "_fetch_valid"}, FETCH_VALID, 0);
      chk({tag, "_fetch_idx"}, FETCH_IDX, 0);
      chk({tag, "_req_full"}, REQ_FULL, 0);
      chk({tag, "_busy"}, BUSY, 0);
      chk({tag, "_done"}, DONE, 0);
      chk({tag, "_err"}, ERR, 0);
   endtask

   task automatic wait_done(string tag);
      bit prev_busy = 1'b0;
      bit seen = 1'b0;
      int extra = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         if (DONE) begin
            seen = 1'b1;
            break;
         end
         prev_busy = BUSY;
      end
      if (!seen) begin
         fail({tag, "_done_timeout"}, "DONE not seen within 400 cycles, required one pulse");
      end else begin
         chk({tag, "_busy_before_done"}, prev_busy, 1);
         chk({tag, "_busy_at_done"}, BUSY, 0);
         for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (DONE) extra++;
         end
         chk({tag, "_done_single"}, extra, 0);
      end
      step();
   endtask

   // ---------------- source driver ----------------
   always @(posedge CLK) begin
      #1;
      cyc++;
      if (src_due.size() > 0 && src_due[0] <= cyc) begin
         SRC_VALID = 1'b1;
         SRC_DIN = src_dat.pop_front();
         void'(src_due.pop_front());
      end else begin
         SRC_VALID = 1'b0;
         SRC_DIN = '0;
      end
      if (rand_ready) FETCH_READY = 1'($urandom_range(0, 1));
   end

   // ---------------- compare process ----------------
   always @(negedge CLK) begin
      if (RST) begin
         int lat;
         int due;
         if (SRC_VALID && !seen_src) begin
            seen_src = 1'b1;
            first_src_hs = hs_total;
         end
         if (FETCH_VALID && FETCH_READY) begin
            hs_total++;
            fetch_cnt[int'(FETCH_IDX)]++;
            if (fetch_q.size() == 0)
               fail("fetch_unexpected", $sformatf("fetch of channel %0d, required no fetch", FETCH_IDX));
            else
               chk("fetch_idx", FETCH_IDX, fetch_q.pop_front());
            lat = rand_lat ? int'($urandom_range(1, 6)) : src_lat;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            src_due.push_back(due);
            src_dat.push_back(rec(int'(FETCH_IDX), src_cnt[int'(FETCH_IDX)]));
            src_cnt[int'(FETCH_IDX)]++;
         end
         if (DOTEN) begin
            if (exp_dat.size() == 0) begin
               fail("dot_unexpected", $sformatf("DOTEN with DOT=%h idx=%0d, required no output", DOT, DOT_IDX));
            end else begin
               chk("dot_data", DOT, exp_dat.pop_front());
               chk("dot_idx", DOT_IDX, exp_idx.pop_front());
               if (log_en) log_dat.push_back(DOT);
            end
         end
         if (DONE) chk("done_pending_outputs", exp_dat.size(), 0);
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < NCH; i++) begin
         model_rem[i] = 0; model_used[i] = 0; src_cnt[i] = 0; fetch_cnt[i] = 0;
      end

      // Reset held for two cycles
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check_reset_outputs("reset");
      @(posedge CLK); #1;
      RST = 1'b1;
      step();

      // Zero-length channel answers with a sentinel two cycles after the request
      load_len(0, 3); load_len(1, 1); load_len(2, 0); load_len(3, 2);
      start_run();
      chk("busy_after_start", BUSY, 1);
      send_req(2);
      @(negedge CLK);
      chk("sent_no_fetch", FETCH_VALID, 0);
      chk("sent_not_early", DOTEN, 0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("sent_doten", DOTEN, 1);
      chk("sent_dot", DOT, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("sent_dot_idx", DOT_IDX, 2);
      step();

      // Channel 0 with three records, four requests
      src_lat = 3;
      FETCH_READY = 1'b1;
      log_en = 1'b1;
      for (int i = 0; i < 4; i++) send_req(0);
      repeat (25) step();
      log_en = 1'b0;
      chk("ch0_fetches", fetch_cnt[0], 3);
      chk("ch0_outputs", log_dat.size(), 4);
      if (log_dat.size() == 4) begin
         chk("ch0_rec0", log_dat[0], rec(0, 0));
         chk("ch0_rec1", log_dat[1], rec(0, 1));
         chk("ch0_rec2", log_dat[2], rec(0, 2));
         chk("ch0_sentinel", log_dat[3], 64'hFFFF_FFFF_FFFF_FFFF);
      end

      // Request queue overflow
      FETCH_READY = 1'b0;
      for (int i = 0; i < 4; i++) send_req(3);
      chk("req_full_set", REQ_FULL, 1);
      chk("err_before_drop", ERR, 0);
      REQ_VALID = 1'b1;
      REQ = 2'd1;
      step();
      REQ_VALID = 1'b0;
      chk("err_on_drop", ERR, 1);
      chk("req_full_hold", REQ_FULL, 1);
      FETCH_READY = 1'b1;
      send_req(1);
      send_req(1);
      wait_done("run1");
      chk("idle_fetch_valid", FETCH_VALID, 0);

      // Fetch window limited by the tag queue
      load_len(0, 8);
      start_run();
      chk("err_cleared_by_start", ERR, 0);
      src_lat = 10;
      seen_src = 1'b0;
      hs_total = 0;
      for (int i = 0; i < 6; i++) send_req(0);
      g = 0;
      while (!seen_src && g < 60) begin
         step();
         g++;
      end
      if (!seen_src) fail("src_timeout", "no source return within 60 cycles, required one");
      else chk("hs_before_first_src", first_src_hs, 4);
      repeat (2) step();

      // Reset in the middle of the run
      RST = 1'b0;
      step();
      exp_dat.delete(); exp_idx.delete(); fetch_q.delete();
      for (int i = 0; i < NCH; i++) model_rem[i] = 0;
      step();
      check_reset_outputs("midrun_reset");
      RST = 1'b1;
      g = 0;
      while (src_due.size() > 0 && g < 200) begin
         step();
         g++;
      end
      step();
      chk("stray_returns_no_err", ERR, 0);
      chk("stray_returns_idle", BUSY, 0);
      for (int i = 0; i < NCH; i++) begin
         model_used[i] = 0;
         src_cnt[i] = 0;
      end

      // Randomised runs
      rand_lat = 1'b1;
      rand_ready = 1'b1;
      for (int run = 0; run < 4; run++) begin
         for (int c = 0; c < NCH; c++) load_len(c, int'($urandom_range(0, 5)));
         start_run();
         for (int r = 0; r < 16; r++) begin
            tot = 0;
            for (int c = 0; c < NCH; c++) tot += model_rem[c];
            if (tot == 0) break;
            ch = int'($urandom_range(0, 3));
            while (model_rem[ch] == 0) ch = (ch + 1) % NCH;
            send_req(ch);
            repeat ($urandom_range(0, 2)) step();
         end
         for (int c = 0; c < NCH; c++) begin
            while (model_rem[c] > 0) send_req(c);
            send_req(c);
            repeat ($urandom_range(0, 1)) step();
         end
         wait_done($sformatf("rand%0d", run));
         chk("rand_outputs_drained", exp_dat.size(), 0);
         chk("rand_fetches_drained", fetch_q.size(), 0);
      end
      rand_ready = 1'b0;
      FETCH_READY = 1'b0;
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
